// File: rtl/fb_bank_ctrl_if.sv
// Bundle of pixel-write, display-read and VRAM port signals for the
// double-buffered frame-buffer bank controller.
interface fb_bank_ctrl_if;
  // core / display side
  logic        ce_pix;
  logic        frame;
  logic        vblank;
  logic        wr_valid;
  logic [7:0]  wr_x;
  logic [7:0]  wr_y;
  logic [7:0]  wr_data;
  logic        rd_en;
  logic [8:0]  rd_x;
  logic [8:0]  rd_y;
  logic [7:0]  pix_out;
  logic        draw_bank;
  logic        ovf;
  // single-port VRAM side
  logic [16:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;

  // Environment: video core, display timing and the VRAM itself.
  modport master (
    output ce_pix, frame, vblank, wr_valid, wr_x, wr_y, wr_data,
    output rd_en, rd_x, rd_y, ram_dout,
    input  pix_out, draw_bank, ovf, ram_addr, ram_din, ram_we
  );

  // Controller.
  modport slave (
    input  ce_pix, frame, vblank, wr_valid, wr_x, wr_y, wr_data,
    input  rd_en, rd_x, rd_y, ram_dout,
    output pix_out, draw_bank, ovf, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/fb_bank_ctrl.sv
// Double-buffered frame-buffer bank controller. Arbitrates one single-port
// VRAM between display reads (priority) and queued core pixel writes, and
// swaps the draw/display banks on a frame-complete edge once vblank is
// reached and all queued writes have landed in the old bank.
module fb_bank_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input logic        clk_sys,
  input logic        reset,
  fb_bank_ctrl_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);

  // Each queued pixel carries the bank that was being drawn when it arrived,
  // so writes queued before a swap still land in the old bank.
  typedef struct packed {
    logic       bank;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    DRAIN
  } swap_state_t;

  swap_state_t state;
  logic        draw_bank;
  logic        frame_q;
  logic        armed;
  logic        frame_edge;

  entry_t      fifo_mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  entry_t      head;

  logic        read_issue;
  logic        pop;
  logic        push;
  logic        drop;
  logic        ovf;

  logic [16:0] addr_q;
  logic [7:0]  din_q;
  logic [16:0] ram_addr_c;
  logic [7:0]  ram_din_c;
  logic        ram_we_c;

  logic        rd_pend;
  logic        rd_kind;
  logic [7:0]  pix_out;

  // Display counters are 9 bits wide but only 256x256 is stored.
  logic        unused_rd_msb;
  assign unused_rd_msb = bus.rd_x[8] ^ bus.rd_y[8];

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head       = fifo_mem[rd_ptr[PW-1:0]];

  // Reset gates all bus activity in its own cycle so queued writes die at once.
  assign read_issue = ~reset & bus.ce_pix & bus.rd_en;
  assign pop        = ~reset & ~read_issue & ~fifo_empty;
  assign push       = ~reset & bus.wr_valid & (~fifo_full | pop);
  assign drop       = ~reset & bus.wr_valid & fifo_full & ~pop;

  // armed suppresses a false edge when frame is already high out of reset.
  assign frame_edge = armed & bus.frame & ~frame_q;

  // VRAM port mux: read first, then a queued write, else hold the bus.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    ram_addr_c = addr_q;
    ram_din_c  = din_q;
    ram_we_c   = 1'b0;
    if (read_issue) begin
      ram_addr_c = {~draw_bank, bus.rd_y[7:0], bus.rd_x[7:0]};
    end else if (pop) begin
      ram_addr_c = {head.bank, head.y, head.x};
      ram_din_c  = head.data;
      ram_we_c   = 1'b1;
    end
  end

  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_din   = ram_din_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.pix_out   = pix_out;
  assign bus.draw_bank = draw_bank;
  assign bus.ovf       = ovf;

  // Remember the last driven address/data so an idle bus holds its value.
  always_ff @(posedge clk_sys) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      addr_q <= ram_addr_c;
      din_q  <= ram_din_c;
    end
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk_sys) begin
    // NOTE: the storage array is deliberately not reset; emptiness is
    // carried by the pointers alone, keeping the array as plain RAM.
    if (push) begin
      fifo_mem[wr_ptr[PW-1:0]] <= '{bank: draw_bank, x: bus.wr_x,
                                    y: bus.wr_y, data: bus.wr_data};
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) ovf    <= 1'b1;
    end
  end

  // Display pipeline: issue cycle, RAM latency cycle, then capture.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_kind <= 1'b0;
      pix_out <= '0;
    end else begin
      rd_pend <= bus.ce_pix;
      rd_kind <= bus.rd_en;
      if (rd_pend) pix_out <= rd_kind ? bus.ram_dout : 8'h00;
    end
  end

  // Frame-edge detector and bank-swap FSM with registered draw_bank.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      frame_q   <= 1'b0;
      armed     <= 1'b0;
      state     <= IDLE;
      draw_bank <= 1'b0;
    end else begin
      frame_q <= bus.frame;
      armed   <= 1'b1;
      case (state)
        IDLE:  if (frame_edge) state <= PEND;
        PEND:  if (bus.vblank) state <= DRAIN;
        // An empty FIFO cannot pop, so this is also the "no write" cycle.
        DRAIN: if (fifo_empty) begin
                 state     <= IDLE;
                 draw_bank <= ~draw_bank;
               end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_bank_ctrl.sv
// Directed testbench for fb_bank_ctrl with a registered-read VRAM model.
module tb_fb_bank_ctrl;

  logic clk_sys = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  localparam logic [16:0] RD_ADDR = 17'h10105;
  localparam logic [7:0]  RD_DATA = 8'h3C;

  fb_bank_ctrl_if bus ();

  fb_bank_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // VRAM model: one-cycle read latency; one fixed location preloaded.
  logic [7:0] mem [0:131071];
  always @(posedge clk_sys) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= (bus.ram_addr == RD_ADDR) ? RD_DATA : mem[bus.ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.ce_pix   = 1'b0;
    bus.frame    = 1'b0;
    bus.vblank   = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_x     = '0;
    bus.wr_y     = '0;
    bus.wr_data  = '0;
    bus.rd_en    = 1'b0;
    bus.rd_x     = '0;
    bus.rd_y     = '0;
  endtask

  task automatic write_px(input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_x     = x;
    bus.wr_y     = y;
    bus.wr_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset state ----
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("rst_draw_bank", bus.draw_bank, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_din", bus.ram_din, 0);
    check("rst_pix_out", bus.pix_out, 0);
    check("rst_ovf", bus.ovf, 0);
    reset = 1'b0;
    tick();

    // ---- single write, no reads ----
    write_px(8'd3, 8'd2, 8'hA5);
    tick();
    bus.wr_valid = 1'b0;
    settle();
    check("wr_we", bus.ram_we, 1);
    check("wr_addr", bus.ram_addr, 17'h00203);
    check("wr_din", bus.ram_din, 8'hA5);
    tick();
    settle();
    check("wr_we_off", bus.ram_we, 0);
    check("wr_addr_hold", bus.ram_addr, 17'h00203);
    check("wr_mem", mem[17'h00203], 8'hA5);

    // ---- display read, bit 8 of counters ignored ----
    bus.ce_pix = 1'b1;
    bus.rd_en  = 1'b1;
    bus.rd_x   = 9'h105;
    bus.rd_y   = 9'h101;
    settle();
    check("rd_addr", bus.ram_addr, 17'h10105);
    check("rd_we", bus.ram_we, 0);
    tick();
    bus.ce_pix = 1'b0;
    settle();
    check("rd_not_early", bus.pix_out, 0);
    tick();
    check("rd_pix", bus.pix_out, 8'h3C);
    // blanking pixel
    bus.ce_pix = 1'b1;
    bus.rd_en  = 1'b0;
    tick();
    bus.ce_pix = 1'b0;
    settle();
    check("blank_hold", bus.pix_out, 8'h3C);
    tick();
    check("blank_pix", bus.pix_out, 8'h00);

    // ---- reads every cycle, 5 writes into a 4-deep FIFO ----
    bus.ce_pix = 1'b1;
    bus.rd_en  = 1'b1;
    bus.rd_x   = '0;
    bus.rd_y   = '0;
    for (int i = 0; i < 5; i++) begin
      write_px(8'(10 + i), 8'd7, 8'(8'h50 + i));
      settle();
      check("ovf_rd_addr", bus.ram_addr, 17'h10000);
      check("ovf_no_we", bus.ram_we, 0);
      tick();
    end
    bus.wr_valid = 1'b0;
    settle();
    check("ovf_set", bus.ovf, 1);
    bus.ce_pix = 1'b0;
    settle();
    check("q0_we", bus.ram_we, 1);
    check("q0_addr", bus.ram_addr, 17'h0070A);
    check("q0_din", bus.ram_din, 8'h50);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("qn_we", bus.ram_we, 1);
      check("qn_addr", bus.ram_addr, 17'h0070A + 17'(i));
      check("qn_din", bus.ram_din, 8'(8'h50 + i));
    end
    tick();
    check("q5_dropped", bus.ram_we, 0);
    check("ovf_sticky", bus.ovf, 1);

    // ---- swap: wait for vblank, second edge absorbed ----
    bus.frame = 1'b1;
    tick();
    tick();
    tick();
    check("swap_wait_vblank", bus.draw_bank, 0);
    bus.frame = 1'b0;
    tick();
    bus.frame = 1'b1;
    tick();
    bus.vblank = 1'b1;
    tick();
    check("swap_drain", bus.draw_bank, 0);
    tick();
    check("swap_toggle", bus.draw_bank, 1);
    for (int i = 0; i < 5; i++) tick();
    check("swap_once", bus.draw_bank, 1);
    bus.vblank = 1'b0;

    // ---- swap with 3 queued writes drains to old bank first ----
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst2_ovf", bus.ovf, 0);
    check("rst2_bank", bus.draw_bank, 0);
    bus.ce_pix = 1'b1;
    bus.rd_en  = 1'b1;
    write_px(8'd1, 8'd9, 8'h11);
    tick();
    write_px(8'd2, 8'd9, 8'h22);
    tick();
    write_px(8'd3, 8'd9, 8'h33);
    tick();
    bus.wr_valid = 1'b0;
    bus.frame    = 1'b1;
    bus.vblank   = 1'b1;
    tick();
    tick();
    check("drain_bank_old", bus.draw_bank, 0);
    bus.ce_pix = 1'b0;
    settle();
    check("drain0_we", bus.ram_we, 1);
    check("drain0_addr", bus.ram_addr, 17'h00901);
    check("drain0_din", bus.ram_din, 8'h11);
    tick();
    check("drain1_addr", bus.ram_addr, 17'h00902);
    check("drain1_din", bus.ram_din, 8'h22);
    tick();
    check("drain2_addr", bus.ram_addr, 17'h00903);
    check("drain2_din", bus.ram_din, 8'h33);
    tick();
    check("drain_done_we", bus.ram_we, 0);
    check("drain_bank_hold", bus.draw_bank, 0);
    tick();
    check("drain_toggle", bus.draw_bank, 1);
    write_px(8'd4, 8'd9, 8'h44);
    tick();
    bus.wr_valid = 1'b0;
    settle();
    check("new_bank_addr", bus.ram_addr, 17'h10904);
    check("new_bank_we", bus.ram_we, 1);
    tick();
    bus.vblank = 1'b0;

    // ---- reset mid-operation: 2 queued, FSM pending ----
    bus.ce_pix = 1'b1;
    bus.rd_en  = 1'b1;
    bus.frame  = 1'b0;
    write_px(8'd1, 8'd1, 8'h01);
    tick();
    bus.frame = 1'b1;
    write_px(8'd2, 8'd1, 8'h02);
    tick();
    bus.wr_valid = 1'b0;
    bus.ce_pix   = 1'b0;
    reset        = 1'b1;
    settle();
    check("rst3_we_now", bus.ram_we, 0);
    tick();
    reset = 1'b0;
    settle();
    check("rst3_we", bus.ram_we, 0);
    check("rst3_bank", bus.draw_bank, 0);
    check("rst3_addr", bus.ram_addr, 0);
    check("rst3_pix", bus.pix_out, 0);
    tick();
    check("rst3_we_1", bus.ram_we, 0);
    tick();
    check("rst3_we_2", bus.ram_we, 0);
    // frame held high through reset must not count as an edge
    bus.vblank = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("rst3_fsm_idle", bus.draw_bank, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
